// File: rtl/slow_tick_timer.sv
// slow_tick_timer: synchronizes a 10 Hz reference into single-cycle ticks, runs a
// start/stop/clear match clock (MM:SS.t) and flags a missing reference.
module slow_tick_timer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 12_000_000,
  parameter int MAX_MINUTES    = 99
) (
  input  logic       clk_fpga,
  input  logic       rst,
  input  logic       clk_10Hz_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       tick_10Hz,
  output logic [3:0] tenths,
  output logic [5:0] seconds,
  output logic [6:0] minutes,
  output logic       running,
  output logic       clk_lost
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0] vld;
  logic hist;
  logic [WW-1:0] wd, wd_nx;
  logic [3:0] tenths_nx;
  logic [5:0] seconds_nx;
  logic [6:0] minutes_nx;
  logic adv, at_max, roll_t, roll_s;
  // vld marks history samples taken from the real input, so a level already
  // high at reset release is never mistaken for a rising edge
  assign tick_10Hz = sync[SYNC_STAGES-1] & ~hist & vld[SYNC_STAGES];
  assign running = state == RUN;
  assign adv = tick_10Hz && state == RUN && !clear;
  assign roll_t = tenths == 4'd9;
  assign roll_s = roll_t && seconds == 6'd59;
  assign at_max = roll_s && minutes == 7'(MAX_MINUTES);
  assign wd_nx = tick_10Hz ? '0 : (wd == WD_MAX ? wd : wd + WW'(1));
  always_comb begin
    state_nx = state;
    tenths_nx = tenths;
    seconds_nx = seconds;
    minutes_nx = minutes;
    if (adv && !at_max) begin
      tenths_nx = roll_t ? 4'd0 : tenths + 4'd1;
      seconds_nx = !roll_t ? seconds : (roll_s ? 6'd0 : seconds + 6'd1);
      minutes_nx = roll_s ? minutes + 7'd1 : minutes;
    end
    if (clear) begin
      state_nx = IDLE;
      tenths_nx = '0;
      seconds_nx = '0;
      minutes_nx = '0;
    end else if (adv && at_max) state_nx = PAUSED;
    else if (stop) state_nx = state == RUN ? PAUSED : state;
    else if (start) state_nx = RUN;
  end
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      sync <= '0;
      vld <= '0;
      hist <= 1'b0;
      wd <= '0;
      clk_lost <= 1'b0;
      state <= IDLE;
      tenths <= '0;
      seconds <= '0;
      minutes <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_10Hz_in};
      vld <= {vld[SYNC_STAGES-1:0], 1'b1};
      hist <= sync[SYNC_STAGES-1];
      wd <= wd_nx;
      clk_lost <= !tick_10Hz && (clk_lost || wd_nx == WD_MAX);
      state <= state_nx;
      tenths <= tenths_nx;
      seconds <= seconds_nx;
      minutes <= minutes_nx;
    end
  end
endmodule

// File: tb/tb_slow_tick_timer.sv
// tb_slow_tick_timer: table rows, corner sequences and random traffic, all checked
// against an arithmetic model (elapsed tenths, edge history, cycles since last tick).
module tb_slow_tick_timer;
  localparam int T = 50;
  localparam int MAXM = 2;
  localparam int TMAX = MAXM * 600 + 599;
  logic clk = 1'b0, rst = 1'b1;
  logic clk_10Hz_in = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic tick_10Hz, running, clk_lost;
  logic [3:0] tenths;
  logic [5:0] seconds;
  logic [6:0] minutes;
  int tests = 0, fails = 0;
  int n, since, m_state, tt;
  logic s0, s1, s2, obs_tick, obs_lost;
  slow_tick_timer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(T), .MAX_MINUTES(MAXM)) dut (
    .clk_fpga(clk), .rst(rst), .clk_10Hz_in(clk_10Hz_in), .start(start), .stop(stop),
    .clear(clear), .tick_10Hz(tick_10Hz), .tenths(tenths), .seconds(seconds),
    .minutes(minutes), .running(running), .clk_lost(clk_lost));
  always #5 clk = ~clk;
  typedef struct {
    logic st, sp, cl;
    int ticks, half, mm, ss, tn;
    logic run;
  } row_t;
  row_t rows[11];
  task automatic chk(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, want);
    end
  endtask
  function automatic int outs();
    return {tick_10Hz, clk_lost, running, minutes, seconds, tenths};
  endfunction
  task automatic cyc(input logic a, input logic st, input logic sp, input logic cl);
    logic t, sat;
    clk_10Hz_in = a; start = st; stop = sp; clear = cl;
    @(negedge clk);
    t = n >= 3 && s1 && !s2;
    chk("cycle", outs(), {t, since >= T - 1, m_state == 1, 7'(tt / 600), 6'((tt / 10) % 60), 4'(tt % 10)});
    obs_tick = tick_10Hz;
    obs_lost = clk_lost;
    @(posedge clk);
    since = t ? 0 : since + 1;
    sat = 1'b0;
    if (t && m_state == 1 && !cl) begin
      if (tt == TMAX) sat = 1'b1;
      else tt++;
    end
    if (cl) begin m_state = 0; tt = 0; end
    else if (sat) m_state = 2;
    else if (sp) begin if (m_state == 1) m_state = 2; end
    else if (st) m_state = 1;
    s2 = s1; s1 = s0; s0 = a; n++;
    #1;
  endtask
  task automatic do_reset(input logic a);
    rst = 1'b1; clk_10Hz_in = a; start = 1'b0; stop = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("reset", outs(), 0);
    n = 0; since = 0; m_state = 0; tt = 0; s0 = 0; s1 = 0; s2 = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic ticks(input int cnt, input int half);
    for (int i = 0; i < cnt; i++) begin
      repeat (half) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (half) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask
  initial begin
    int first, cnt, tk, fl;
    logic a;
    int hl;
    rows[0]  = '{1'b1, 1'b0, 1'b0, 125, 10, 0, 12, 5, 1'b1};
    rows[1]  = '{1'b0, 1'b1, 1'b0, 10, 10, 0, 12, 5, 1'b0};
    rows[2]  = '{1'b0, 1'b0, 1'b1, 0, 10, 0, 0, 0, 1'b0};
    rows[3]  = '{1'b1, 1'b0, 1'b0, 599, 1, 0, 59, 9, 1'b1};
    rows[4]  = '{1'b0, 1'b0, 1'b0, 1, 10, 1, 0, 0, 1'b1};
    rows[5]  = '{1'b0, 1'b0, 1'b0, 1199, 1, 2, 59, 9, 1'b1};
    rows[6]  = '{1'b0, 1'b0, 1'b0, 1, 10, 2, 59, 9, 1'b0};
    rows[7]  = '{1'b1, 1'b0, 1'b0, 1, 10, 2, 59, 9, 1'b0};
    rows[8]  = '{1'b0, 1'b0, 1'b1, 0, 10, 0, 0, 0, 1'b0};
    rows[9]  = '{1'b1, 1'b0, 1'b0, 7, 10, 0, 0, 7, 1'b1};
    rows[10] = '{1'b1, 1'b1, 1'b1, 0, 10, 0, 0, 0, 1'b0};
    do_reset(1'b0);
    foreach (rows[r]) begin
      cyc(1'b0, rows[r].st, rows[r].sp, rows[r].cl);
      ticks(rows[r].ticks, rows[r].half);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("row%0d", r), {minutes, seconds, tenths, running},
          {7'(rows[r].mm), 6'(rows[r].ss), 4'(rows[r].tn), rows[r].run});
    end
    // single rise: one tick, two cycles after the input is first sampled high
    do_reset(1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    first = -1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(i < 20, 1'b0, 1'b0, 1'b0);
      if (obs_tick) begin cnt++; if (first < 0) first = i; end
    end
    chk("rise_tick_count", cnt, 1);
    chk("rise_tick_latency", first, 2);
    // start coincident with a tick from IDLE is not counted
    cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_with_tick", obs_tick, 1);
    repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_tick_ignored", {tenths, running}, {4'd0, 1'b1});
    // stop coincident with a tick in RUN still counts it
    cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("stop_with_tick", obs_tick, 1);
    repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_tick_counted", {tenths, running}, {4'd1, 1'b0});
    // watchdog: lost after T-1 cycles of counting past the last tick
    tk = -1; fl = -1;
    for (int i = 0; i < 70; i++) begin
      cyc(i < 10, 1'b0, 1'b0, 1'b0);
      if (obs_tick && tk < 0) tk = i;
      if (obs_lost && tk >= 0 && fl < 0) fl = i;
    end
    chk("lost_delay", fl - tk - 1, T - 1);
    chk("lost_hold", obs_lost, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lost_at_tick", {obs_tick, obs_lost}, 2'b11);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lost_clears", obs_lost, 0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // reset at 00:07.3 with the input high: no tick until it falls and rises
    do_reset(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(72, 10);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_time", {minutes, seconds, tenths, running}, {7'd0, 6'd7, 4'd3, 1'b1});
    do_reset(1'b1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin cyc(1'b1, 1'b0, 1'b0, 1'b0); cnt += int'(obs_tick); end
    chk("no_tick_high_at_release", cnt, 0);
    chk("post_reset_state", {minutes, seconds, tenths, running}, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin cyc(i >= 10, 1'b0, 1'b0, 1'b0); cnt += int'(obs_tick); end
    chk("tick_after_refall", cnt, 1);
    // random traffic against the model
    do_reset(1'b0);
    a = 1'b0; hl = 5;
    for (int i = 0; i < 6000; i++) begin
      if (--hl <= 0) begin
        a = ~a;
        hl = $urandom_range(0, 15) == 0 ? $urandom_range(40, 70) : $urandom_range(1, 12);
      end
      if ($urandom_range(0, 1999) == 0) do_reset(a);
      cyc(a, $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
